turn_sequencer: RTL and testbench
=================================

// Module: turn_sequencer
// PURPOSE
//  Upstream turn controller for the Chicken Cha-Cha-Cha datapath. Latches the
//  player's tile selection, strobes the datapath compare (A) and advance (B)
//  inputs, and waits for the go/W results. Holds a mismatched tile face-up for
//  a fixed reveal time, then pulses statecombo_next_turn to rotate players.
// PARAMETERS
//  REVEAL_CYCLES   50_000_000  clocks a mismatched tile stays revealed (1 s @ 50 MHz)
//  TIMEOUT_CYCLES  500_000_000 clocks allowed for a selection (TURN_TIMEOUT_EN only)
//  CNT_W           29          shared timer width; must hold max(REVEAL_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  clk                   in   1  system clock, rising edge
//  rst                   in   1  asynchronous, active-low reset
//  start                 in   1  one-cycle pulse: begin a new game
//  sel_valid             in   1  one-cycle pulse: player confirmed a tile
//  sel_pos               in   4  tile index; sampled with sel_valid
//  N                     in   2  player-count code; last player index = (N==0 ? 1 : N)
//  go                    in   1  datapath match result; valid 1 clk after A
//  W                     in   1  datapath win flag; valid 1 clk after B
//  position_data         out  4  latched selection to datapath
//  A                     out  1  one-cycle compare strobe
//  B                     out  1  one-cycle advance strobe
//  statecombo_next_turn  out  1  one-cycle turn-rotate pulse
//  reveal                out  1  selected tile shown face-up
//  cur_player            out  2  index of player to move
//  game_over             out  1  high from win until next start
// BEHAVIOUR
//  - Reset (any time, incl. mid-turn): state IDLE; every output 0; timer 0.
//  - All outputs registered. States and transitions:
//    IDLE: start -> WAIT_SEL, cur_player=0.
//    WAIT_SEL: sel_valid -> latch position_data=sel_pos, -> CHECK.
//      sel_valid in every other state is ignored.
//    CHECK: A=1 for exactly one clk; reveal=1; -> WAIT_RES.
//    WAIT_RES: sample go. go=1 -> ADVANCE; go=0 -> REVEAL, timer cleared.
//    ADVANCE: B=1 for exactly one clk -> WAIT_WIN.
//    WAIT_WIN: sample W. W=1 -> WIN; W=0 -> WAIT_SEL, reveal=0, same player.
//    REVEAL: reveal=1; timer counts to REVEAL_CYCLES-1, then -> NEXT.
//    NEXT: statecombo_next_turn=1 for one clk; reveal=0; cur_player increments,
//      wrapping to 0 after (N==0 ? 1 : N); -> WAIT_SEL.
//    WIN: game_over=1, reveal=0; start -> game_over=0, cur_player=0, WAIT_SEL.
//  - start is ignored outside IDLE and WIN.
//  - A, B and statecombo_next_turn are mutually exclusive; never high on
//    consecutive clocks.
//  - N is sampled at the NEXT transition; changing N mid-game affects only
//    later wraps. If cur_player already exceeds the new limit, it wraps to 0.
//  - Timer saturates; it never wraps back into the count.
// CONFIGURATION
//  TURN_TIMEOUT_EN defined: in WAIT_SEL the timer counts. At TIMEOUT_CYCLES-1
//    with no sel_valid, the turn is forfeited: -> NEXT (no A/B, reveal=0).
//    If sel_valid arrives on the timeout clock, the selection wins.
//    The timer clears on every entry to WAIT_SEL.
//  TURN_TIMEOUT_EN undefined: WAIT_SEL waits indefinitely; the timer is idle
//    there and no timeout logic is synthesised.
// TESTING (sim: REVEAL_CYCLES=8, TIMEOUT_CYCLES=20)
//  1 start; sel_valid sel_pos=4'd5; go=1 then W=0 -> position_data=5, A 1 clk,
//    B 1 clk, back to WAIT_SEL, cur_player=0, no next-turn pulse.
//  2 N=2, three mismatches (go=0) -> reveal high 8 clks each; next-turn pulses;
//    cur_player 0->1->2->0.
//  3 match with W=1 -> game_over=1; sel_valid ignored; start -> game_over=0,
//    cur_player=0.
//  4 rst low during REVEAL -> all outputs 0 immediately (async); after release,
//    state is IDLE and stays there until start.
//  5 sel_valid during CHECK/REVEAL, start mid-game -> no effect on
//    position_data, state or strobes.
//  6 TURN_TIMEOUT_EN: no selection for 20 clks -> next-turn pulse, cur_player+1,
//    A never asserted.

Source files
------------

// File: rtl/turn_sequencer.sv
// Turn controller for the Chicken Cha-Cha-Cha datapath: selection, compare/advance strobes,
// mismatch reveal and player rotation. Define TURN_TIMEOUT_EN to enable selection timeout.
module turn_sequencer #(
  parameter int unsigned REVEAL_CYCLES  = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned CNT_W          = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_valid,
  input  logic [3:0] sel_pos,
  input  logic [1:0] N,
  input  logic       go,
  input  logic       W,
  output logic [3:0] position_data,
  output logic       A,
  output logic       B,
  output logic       statecombo_next_turn,
  output logic       reveal,
  output logic [1:0] cur_player,
  output logic       game_over
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WAIT_SEL = 4'd1;
  localparam logic [3:0] S_CHECK    = 4'd2;
  localparam logic [3:0] S_WAIT_RES = 4'd3;
  localparam logic [3:0] S_ADVANCE  = 4'd4;
  localparam logic [3:0] S_WAIT_WIN = 4'd5;
  localparam logic [3:0] S_REVEAL   = 4'd6;
  localparam logic [3:0] S_NEXT     = 4'd7;
  localparam logic [3:0] S_WIN      = 4'd8;

  localparam logic [CNT_W-1:0] LP_REV_LAST = CNT_W'(REVEAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_SAT      = {CNT_W{1'b1}};

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [3:0]       w_state_d;
  logic [CNT_W-1:0] w_timer_d;
  logic [3:0]       w_pos_d;
  logic [1:0]       w_cur_d;
  logic [1:0]       w_last;
  logic [1:0]       w_cur_inc;
  logic             w_timer_run;

  assign w_last    = (N == 2'd0) ? 2'd1 : N;
  // >= also folds a player index left stranded above a newly lowered limit back to 0
  assign w_cur_inc = (cur_player >= w_last) ? 2'd0 : cur_player + 2'd1;

`ifdef TURN_TIMEOUT_EN
  assign w_timer_run = (r_state == S_REVEAL) || (r_state == S_WAIT_SEL);
`else
  assign w_timer_run = (r_state == S_REVEAL);
  logic w_unused_timeout;
  assign w_unused_timeout = ^LP_TO_LAST;
`endif

  always_comb begin
    w_state_d = r_state;
    w_pos_d   = position_data;
    w_cur_d   = cur_player;
    case (r_state)
      S_IDLE, S_WIN: begin
        if (start) begin
          w_state_d = S_WAIT_SEL;
          w_cur_d   = 2'd0;
        end
      end
      S_WAIT_SEL: begin
        if (sel_valid) begin
          w_pos_d   = sel_pos;
          w_state_d = S_CHECK;
        end
`ifdef TURN_TIMEOUT_EN
        else if (r_timer == LP_TO_LAST) begin
          w_state_d = S_NEXT;
        end
`endif
      end
      S_CHECK:    w_state_d = S_WAIT_RES;
      S_WAIT_RES: w_state_d = go ? S_ADVANCE : S_REVEAL;
      S_ADVANCE:  w_state_d = S_WAIT_WIN;
      S_WAIT_WIN: w_state_d = W ? S_WIN : S_WAIT_SEL;
      S_REVEAL: begin
        if (r_timer == LP_REV_LAST) w_state_d = S_NEXT;
      end
      S_NEXT:     w_state_d = S_WAIT_SEL;
      default:    w_state_d = S_IDLE;
    endcase
    if (w_state_d == S_NEXT) w_cur_d = w_cur_inc;
  end

  always_comb begin
    w_timer_d = r_timer;
    if ((w_state_d != r_state) &&
        ((w_state_d == S_REVEAL) || (w_state_d == S_WAIT_SEL))) begin
      w_timer_d = '0;
    end else if (w_timer_run && (r_timer != LP_SAT)) begin
      w_timer_d = r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state              <= S_IDLE;
      r_timer              <= '0;
      position_data        <= 4'd0;
      A                    <= 1'b0;
      B                    <= 1'b0;
      statecombo_next_turn <= 1'b0;
      reveal               <= 1'b0;
      cur_player           <= 2'd0;
      game_over            <= 1'b0;
    end else begin
      r_state              <= w_state_d;
      r_timer              <= w_timer_d;
      position_data        <= w_pos_d;
      A                    <= (w_state_d == S_CHECK);
      B                    <= (w_state_d == S_ADVANCE);
      statecombo_next_turn <= (w_state_d == S_NEXT);
      reveal               <= (w_state_d == S_CHECK) || (w_state_d == S_WAIT_RES) ||
                              (w_state_d == S_ADVANCE) || (w_state_d == S_WAIT_WIN) ||
                              (w_state_d == S_REVEAL);
      cur_player           <= w_cur_d;
      game_over            <= (w_state_d == S_WIN);
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed self-checking bench for turn_sequencer (REVEAL_CYCLES=8, TIMEOUT_CYCLES=20).
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel_valid = 1'b0;
  logic [3:0] sel_pos = 4'd0;
  logic [1:0] n = 2'd0;
  logic       go = 1'b0;
  logic       w = 1'b0;
  logic [3:0] position_data;
  logic       a, b, nt, reveal, game_over;
  logic [1:0] cur_player;

  int n_cmp = 0;
  int n_mis = 0;
  int a_cnt = 0;
  int b_cnt = 0;
  int nt_cnt = 0;
  logic prev_any = 1'b0;
  logic viol = 1'b0;

  turn_sequencer #(
    .REVEAL_CYCLES (8),
    .TIMEOUT_CYCLES(20),
    .CNT_W         (29)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .sel_valid           (sel_valid),
    .sel_pos             (sel_pos),
    .N                   (n),
    .go                  (go),
    .W                   (w),
    .position_data       (position_data),
    .A                   (a),
    .B                   (b),
    .statecombo_next_turn(nt),
    .reveal              (reveal),
    .cur_player          (cur_player),
    .game_over           (game_over)
  );

  always #5 clk = ~clk;

  // Strobe counters and exclusivity watch, sampled mid-cycle.
  always @(negedge clk) begin
    a_cnt  <= a_cnt + int'(a);
    b_cnt  <= b_cnt + int'(b);
    nt_cnt <= nt_cnt + int'(nt);
    if ((int'(a) + int'(b) + int'(nt)) > 1) viol <= 1'b1;
    if (prev_any && (a || b || nt)) viol <= 1'b1;
    prev_any <= a || b || nt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [3:0] p);
    sel_valid = 1'b1;
    sel_pos   = p;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One mismatched turn: optional stray sel_valid in CHECK, optional stray
  // sel_valid+start injected at REVEAL cycle inj.
  task automatic mismatch(input logic [3:0] pos, input logic [1:0] exp_cur,
                          input bit sel_in_check, input int inj);
    int rev;
    bit seen;
    rev  = 0;
    seen = 1'b0;
    go   = 1'b0;
    select(pos);
    check("mm_a_strobe", a, 1);
    check("mm_reveal_check", reveal, 1);
    if (sel_in_check) begin
      sel_valid = 1'b1;
      sel_pos   = ~pos;
    end
    tick();
    sel_valid = 1'b0;
    check("mm_a_one_clk", a, 0);
    for (int k = 0; k < 30; k++) begin
      if (k == inj) begin
        sel_valid = 1'b1;
        sel_pos   = 4'hf;
        start     = 1'b1;
      end
      tick();
      sel_valid = 1'b0;
      start     = 1'b0;
      if (nt) begin
        seen = 1'b1;
        break;
      end
      if (reveal) rev++;
    end
    check("mm_next_seen", seen, 1);
    check("mm_reveal_len", rev, 8);
    check("mm_cur_player", cur_player, exp_cur);
    check("mm_pos_held", position_data, pos);
    check("mm_reveal_off", reveal, 0);
    tick();
    check("mm_next_one_clk", nt, 0);
  endtask

  initial begin
    int a0, b0, nt0, cnt;
    #1 rst = 1'b0;
    #20;
    check("rst_outputs", {position_data, a, b, nt, reveal, cur_player, game_over}, 0);
    #2 rst = 1'b1;
    tick();
    tick();
    check("idle_outputs", {position_data, a, b, nt, reveal, cur_player, game_over}, 0);

    // 1: matched tile, no win
    n  = 2'd2;
    go = 1'b1;
    w  = 1'b0;
    pulse_start();
    check("t1_cur0", cur_player, 0);
    a0 = a_cnt; b0 = b_cnt; nt0 = nt_cnt;
    select(4'd5);
    check("t1_a", a, 1);
    check("t1_pos", position_data, 5);
    tick();
    check("t1_a_off", a, 0);
    tick();
    check("t1_b", b, 1);
    tick();
    check("t1_b_off", b, 0);
    tick();
    check("t1_reveal_off", reveal, 0);
    check("t1_cur_same", cur_player, 0);
    check("t1_a_cnt", a_cnt - a0, 1);
    check("t1_b_cnt", b_cnt - b0, 1);
    check("t1_nt_cnt", nt_cnt - nt0, 0);

    // 2 and 5: three mismatches with N=2, stray inputs in CHECK/REVEAL
    b0 = b_cnt; a0 = a_cnt;
    mismatch(4'd1, 2'd1, 1'b0, 3);
    mismatch(4'd2, 2'd2, 1'b1, -1);
    mismatch(4'd3, 2'd0, 1'b0, -1);
    check("t2_b_none", b_cnt - b0, 0);
    check("t2_a_cnt", a_cnt - a0, 3);

    // N==0 acts as two players
    n = 2'd0;
    mismatch(4'd8, 2'd1, 1'b0, -1);
    mismatch(4'd9, 2'd0, 1'b0, -1);
    n = 2'd2;
    mismatch(4'd10, 2'd1, 1'b0, -1);

    // start mid-game is ignored
    pulse_start();
    check("t5_start_cur", cur_player, 1);
    check("t5_start_a", a, 0);
    check("t5_start_reveal", reveal, 0);

    // 3: win
    go = 1'b1;
    w  = 1'b1;
    select(4'd7);
    tick();
    tick();
    check("t3_b", b, 1);
    tick();
    tick();
    check("t3_game_over", game_over, 1);
    check("t3_reveal_off", reveal, 0);
    a0 = a_cnt;
    select(4'd3);
    tick();
    check("t3_sel_ignored_pos", position_data, 7);
    check("t3_sel_ignored_a", a_cnt - a0, 0);
    check("t3_still_over", game_over, 1);
    pulse_start();
    check("t3_restart_over", game_over, 0);
    check("t3_restart_cur", cur_player, 0);
    go = 1'b0;
    w  = 1'b0;

    // 4: async reset during REVEAL
    select(4'd4);
    tick();
    tick();
    tick();
    tick();
    check("t4_in_reveal", reveal, 1);
    #2 rst = 1'b0;
    #1;
    check("t4_async_zero", {position_data, a, b, nt, reveal, cur_player, game_over}, 0);
    #22 rst = 1'b1;
    a0 = a_cnt;
    select(4'd6);
    tick();
    tick();
    check("t4_idle_hold", {position_data, a, b, nt, reveal, cur_player, game_over}, 0);
    check("t4_idle_no_a", a_cnt - a0, 0);
    pulse_start();
    mismatch(4'd6, 2'd1, 1'b0, -1);

`ifdef TURN_TIMEOUT_EN
    // 6: selection timeout forfeits the turn
    a0  = a_cnt;
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (nt) begin
        cnt = k;
        break;
      end
    end
    check("t6_timeout_clks", cnt, 20);
    check("t6_cur_inc", cur_player, 2);
    check("t6_reveal_off", reveal, 0);
    check("t6_no_a", a_cnt - a0, 0);
`else
    // without timeout, WAIT_SEL waits indefinitely
    nt0 = nt_cnt;
    for (int k = 0; k < 40; k++) tick();
    check("t6_no_timeout", nt_cnt - nt0, 0);
    check("t6_cur_same", cur_player, 1);
`endif

    tick();
    check("strobe_exclusive", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
